// File: rtl/vpu_pipe_ctrl.sv
// Vector pipeline controller: an in-order tag buffer feeding three overlapping
// stage FSMs (operand fetch, execute, writeback) and a one-entry response slot.
module vpu_pipe_ctrl #(
    parameter int STREAM_ID_WIDTH = 8,
    parameter int INFLIGHT_DEPTH  = 4,
    parameter int SRC_CNT         = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ctrl_valid_i,
    output logic                            ctrl_ready_o,
    input  logic [STREAM_ID_WIDTH-1:0]      stream_id_i,
    input  logic [SRC_CNT-1:0]              src_mask_i,
    output logic                            opget_start_o,
    input  logic                            opget_done_i,
    output logic                            exec_start_o,
    output logic [SRC_CNT-1:0]              operand_rden_o,
    input  logic                            exec_done_i,
    output logic                            wb_start_o,
    output logic                            wb_data_valid_o,
    input  logic                            wb_done_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [STREAM_ID_WIDTH-1:0]      resp_stream_id_o,
    output logic [$clog2(INFLIGHT_DEPTH):0] inflight_cnt_o,
    output logic                            busy_o,
    output logic                            err_o,
    output logic [2:0]                      dbg_state_o
);
    localparam int PW = $clog2(INFLIGHT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(INFLIGHT_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stage_t;

    stage_t r_og_state, r_ex_state, r_wb_state;
    stage_t w_og_next, w_ex_next, w_wb_next;

    logic [STREAM_ID_WIDTH-1:0] r_tag_id   [INFLIGHT_DEPTH];
    logic [SRC_CNT-1:0]         r_tag_mask [INFLIGHT_DEPTH];

    logic [PW-1:0] r_alloc_ptr, r_og_ptr, r_ex_ptr, r_wb_ptr, r_ret_ptr;
    // Per-stage pending counts: entries handed to a stage but not yet started there.
    logic [CW-1:0] r_cnt, r_og_pend, r_ex_pend, r_wb_pend;

    logic                       r_resp_valid;
    logic [STREAM_ID_WIDTH-1:0] r_resp_id;
    logic                       r_err;

    logic w_accept, w_retire, w_resp_free;
    logic w_og_start, w_ex_start, w_wb_start;
    logic w_og_done, w_ex_done, w_wb_done;
    logic w_err_evt;

    // Valid/ready: a transfer happens in any cycle where both are high; the
    // producer holds valid and payload stable until that cycle. Ready never
    // depends on valid and never bypasses a same-cycle retire.
    assign ctrl_ready_o = (r_cnt != DEPTH_C);
    assign w_accept     = ctrl_valid_i && ctrl_ready_o;
    assign w_retire     = r_resp_valid && resp_ready_i;
    assign w_resp_free  = !r_resp_valid || resp_ready_i;

    // Done strobes only count while the stage is BUSY; anything else is a protocol error.
    assign w_og_done = (r_og_state == ST_BUSY) && opget_done_i;
    assign w_ex_done = (r_ex_state == ST_BUSY) && exec_done_i;
    assign w_wb_done = (r_wb_state == ST_BUSY) && wb_done_i;
    assign w_err_evt = (opget_done_i && (r_og_state != ST_BUSY)) ||
                       (exec_done_i  && (r_ex_state != ST_BUSY)) ||
                       (wb_done_i    && (r_wb_state != ST_BUSY));

    always_comb begin
        w_og_next  = r_og_state;
        w_ex_next  = r_ex_state;
        w_wb_next  = r_wb_state;
        w_og_start = 1'b0;
        w_ex_start = 1'b0;
        w_wb_start = 1'b0;

        case (r_og_state)
            ST_IDLE: if (r_og_pend != '0) begin
                w_og_start = 1'b1;
                w_og_next  = ST_BUSY;
            end
            ST_BUSY: if (opget_done_i) w_og_next = ST_IDLE;
            default: w_og_next = ST_IDLE;
        endcase

        case (r_ex_state)
            ST_IDLE: if (r_ex_pend != '0) begin
                w_ex_start = 1'b1;
                w_ex_next  = ST_BUSY;
            end
            ST_BUSY: if (exec_done_i) w_ex_next = ST_IDLE;
            default: w_ex_next = ST_IDLE;
        endcase

        case (r_wb_state)
            ST_IDLE: if ((r_wb_pend != '0) && w_resp_free) begin
                w_wb_start = 1'b1;
                w_wb_next  = ST_BUSY;
            end
            ST_BUSY: if (wb_done_i) w_wb_next = ST_IDLE;
            default: w_wb_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_og_state   <= ST_IDLE;
            r_ex_state   <= ST_IDLE;
            r_wb_state   <= ST_IDLE;
            r_alloc_ptr  <= '0;
            r_og_ptr     <= '0;
            r_ex_ptr     <= '0;
            r_wb_ptr     <= '0;
            r_ret_ptr    <= '0;
            r_cnt        <= '0;
            r_og_pend    <= '0;
            r_ex_pend    <= '0;
            r_wb_pend    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_og_state <= w_og_next;
            r_ex_state <= w_ex_next;
            r_wb_state <= w_wb_next;

            if (w_accept)  r_alloc_ptr <= r_alloc_ptr + PW'(1);
            if (w_og_done) r_og_ptr    <= r_og_ptr + PW'(1);
            if (w_ex_done) r_ex_ptr    <= r_ex_ptr + PW'(1);
            if (w_wb_done) r_wb_ptr    <= r_wb_ptr + PW'(1);
            if (w_retire)  r_ret_ptr   <= r_ret_ptr + PW'(1);

            r_cnt     <= r_cnt + CW'(w_accept) - CW'(w_retire);
            r_og_pend <= r_og_pend + CW'(w_accept) - CW'(w_og_start);
            r_ex_pend <= r_ex_pend + CW'(w_og_done) - CW'(w_ex_start);
            r_wb_pend <= r_wb_pend + CW'(w_ex_done) - CW'(w_wb_start);

            // WB only starts into a free slot, so a load never collides with a held response.
            if (w_wb_done) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_tag_id[r_wb_ptr];
            end else if (w_retire) begin
                r_resp_valid <= 1'b0;
            end

            if (w_err_evt) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_tag_id[r_alloc_ptr]   <= stream_id_i;
            r_tag_mask[r_alloc_ptr] <= src_mask_i;
        end
    end

    assign opget_start_o    = w_og_start;
    assign exec_start_o     = w_ex_start;
    assign operand_rden_o   = w_ex_start ? r_tag_mask[r_ex_ptr] : '0;
    assign wb_start_o       = w_wb_start;
    assign wb_data_valid_o  = w_wb_start;
    assign resp_valid_o     = r_resp_valid;
    assign resp_stream_id_o = r_resp_id;
    assign inflight_cnt_o   = r_cnt;
    assign busy_o           = (r_cnt != '0);
    assign err_o            = r_err;
    assign dbg_state_o      = {r_wb_state, r_ex_state, r_og_state};

endmodule

// File: tb/tb_vpu_pipe_ctrl.sv
// Bench for vpu_pipe_ctrl: a transaction-level in-order pipeline model with
// randomized done latencies, valid gaps and response backpressure.
module tb_vpu_pipe_ctrl;
    localparam int IDW   = 8;
    localparam int DEPTH = 4;
    localparam int SRC   = 3;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXN  = 1024;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [SRC-1:0] mask;
    } ins_t;

    logic           clk;
    logic           rst_n;
    logic           ctrl_valid_i;
    logic           ctrl_ready_o;
    logic [IDW-1:0] stream_id_i;
    logic [SRC-1:0] src_mask_i;
    logic           opget_start_o;
    logic           opget_done_i;
    logic           exec_start_o;
    logic [SRC-1:0] operand_rden_o;
    logic           exec_done_i;
    logic           wb_start_o;
    logic           wb_data_valid_o;
    logic           wb_done_i;
    logic           resp_valid_o;
    logic           resp_ready_i;
    logic [IDW-1:0] resp_stream_id_o;
    logic [CW-1:0]  inflight_cnt_o;
    logic           busy_o;
    logic           err_o;
    logic [2:0]     dbg_state_o;

    vpu_pipe_ctrl #(
        .STREAM_ID_WIDTH(IDW),
        .INFLIGHT_DEPTH (DEPTH),
        .SRC_CNT        (SRC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ctrl_valid_i    (ctrl_valid_i),
        .ctrl_ready_o    (ctrl_ready_o),
        .stream_id_i     (stream_id_i),
        .src_mask_i      (src_mask_i),
        .opget_start_o   (opget_start_o),
        .opget_done_i    (opget_done_i),
        .exec_start_o    (exec_start_o),
        .operand_rden_o  (operand_rden_o),
        .exec_done_i     (exec_done_i),
        .wb_start_o      (wb_start_o),
        .wb_data_valid_o (wb_data_valid_o),
        .wb_done_i       (wb_done_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_stream_id_o(resp_stream_id_o),
        .inflight_cnt_o  (inflight_cnt_o),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    ins_t src_q[$];
    logic [IDW-1:0] id_a   [MAXN];
    logic [SRC-1:0] mask_a [MAXN];
    int n_acc, n_ret, og_n, og_dn, ex_n, ex_dn, wb_n, wb_dn;
    bit og_busy, ex_busy, wb_busy, resp_full, err_exp, last_acc;
    int og_wait, ex_wait, wb_wait;
    int lat_min, lat_max, valid_pct, rr_pct;
    bit hold_dones;
    int wb_obs;

    int acc_c [MAXN];
    int ret_c [MAXN];
    int og_sc [MAXN];
    int ex_sc [MAXN];
    int ex_dc [MAXN];
    int wb_sc [MAXN];
    int rsp_c [MAXN];
    logic [SRC-1:0] rd_obs [MAXN];
    logic [IDW-1:0] id_obs [MAXN];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        n_acc = 0; n_ret = 0;
        og_n = 0; og_dn = 0; ex_n = 0; ex_dn = 0; wb_n = 0; wb_dn = 0;
        og_busy = 0; ex_busy = 0; wb_busy = 0; resp_full = 0; err_exp = 0;
        og_wait = 0; ex_wait = 0; wb_wait = 0; last_acc = 0;
        src_q.delete();
        for (int i = 0; i < MAXN; i++) begin
            acc_c[i] = -1; ret_c[i] = -1; og_sc[i] = -1; ex_sc[i] = -1;
            ex_dc[i] = -1; wb_sc[i] = -1; rsp_c[i] = -1;
        end
    endtask

    function automatic int pick_lat();
        if (hold_dones) return 1000000;
        return int'($urandom_range(lat_max, lat_min));
    endfunction

    task automatic zero_inputs();
        ctrl_valid_i = 1'b0;
        stream_id_i  = '0;
        src_mask_i   = '0;
        opget_done_i = 1'b0;
        exec_done_i  = 1'b0;
        wb_done_i    = 1'b0;
        resp_ready_i = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        if (!rst_n) begin
            zero_inputs();
            return;
        end
        if (ctrl_valid_i && !last_acc) begin
            // payload held until accepted
        end else if (src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
            ctrl_valid_i = 1'b1;
            stream_id_i  = src_q[0].id;
            src_mask_i   = src_q[0].mask;
        end else begin
            ctrl_valid_i = 1'b0;
            stream_id_i  = IDW'($urandom);
            src_mask_i   = SRC'($urandom);
        end
        opget_done_i = og_busy && (og_wait == 0);
        if (og_busy && og_wait > 0) og_wait--;
        exec_done_i = ex_busy && (ex_wait == 0);
        if (ex_busy && ex_wait > 0) ex_wait--;
        wb_done_i = wb_busy && (wb_wait == 0);
        if (wb_busy && wb_wait > 0) wb_wait--;
        resp_ready_i = ($urandom_range(99, 0) < rr_pct);
    endtask

    // One clock: check outputs at negedge, advance the model at posedge, redrive.
    task automatic cycle();
        bit e_og, e_ex, e_wb, acc, pop;
        bit c_rst, c_ogd, c_exd, c_wbd;
        logic [IDW-1:0] c_id;
        logic [SRC-1:0] c_mask;
        @(negedge clk);
        cyc++;
        e_og = !og_busy && (og_n < n_acc);
        e_ex = !ex_busy && (ex_n < og_dn);
        e_wb = !wb_busy && (wb_n < ex_dn) && (!resp_full || resp_ready_i);
        if (chk_en) begin
            chk("ready", 32'(ctrl_ready_o), 32'((n_acc - n_ret) != DEPTH));
            chk("cnt", 32'(inflight_cnt_o), 32'(n_acc - n_ret));
            chk("busy", 32'(busy_o), 32'(n_acc != n_ret));
            chk("og_start", 32'(opget_start_o), 32'(e_og));
            chk("ex_start", 32'(exec_start_o), 32'(e_ex));
            chk("rden", 32'(operand_rden_o), e_ex ? 32'(mask_a[ex_n % MAXN]) : 32'd0);
            chk("wb_start", 32'(wb_start_o), 32'(e_wb));
            chk("wb_dv", 32'(wb_data_valid_o), 32'(e_wb));
            chk("resp_valid", 32'(resp_valid_o), 32'(resp_full));
            if (resp_full) chk("resp_id", 32'(resp_stream_id_o), 32'(id_a[n_ret % MAXN]));
            chk("err", 32'(err_o), 32'(err_exp));
            chk("dbg_state", 32'(dbg_state_o), 32'({wb_busy, ex_busy, og_busy}));
        end
        if (opget_start_o === 1'b1) og_sc[og_n % MAXN] = cyc;
        if (exec_start_o === 1'b1) begin
            ex_sc[ex_n % MAXN]  = cyc;
            rd_obs[ex_n % MAXN] = operand_rden_o;
        end
        if (wb_start_o === 1'b1) begin
            wb_sc[wb_n % MAXN] = cyc;
            wb_obs++;
        end
        if (resp_valid_o === 1'b1 && rsp_c[n_ret % MAXN] < 0) begin
            rsp_c[n_ret % MAXN]  = cyc;
            id_obs[n_ret % MAXN] = resp_stream_id_o;
        end
        acc    = ctrl_valid_i && ((n_acc - n_ret) != DEPTH);
        pop    = resp_full && resp_ready_i;
        c_rst  = !rst_n;
        c_ogd  = opget_done_i;
        c_exd  = exec_done_i;
        c_wbd  = wb_done_i;
        c_id   = stream_id_i;
        c_mask = src_mask_i;
        @(posedge clk);
        if (c_rst) begin
            model_reset();
        end else begin
            last_acc = acc;
            if (acc) begin
                id_a[n_acc % MAXN]   = c_id;
                mask_a[n_acc % MAXN] = c_mask;
                acc_c[n_acc % MAXN]  = cyc;
                n_acc++;
                void'(src_q.pop_front());
            end
            if (c_ogd) begin
                if (og_busy) begin og_busy = 0; og_dn++; end
                else err_exp = 1;
            end
            if (c_exd) begin
                if (ex_busy) begin ex_dc[ex_dn % MAXN] = cyc; ex_busy = 0; ex_dn++; end
                else err_exp = 1;
            end
            if (pop) begin
                ret_c[n_ret % MAXN] = cyc;
                resp_full = 0;
                n_ret++;
            end
            if (c_wbd) begin
                if (wb_busy) begin wb_busy = 0; wb_dn++; resp_full = 1; end
                else err_exp = 1;
            end
            if (e_og) begin og_busy = 1; og_n++; og_wait = pick_lat(); end
            if (e_ex) begin ex_busy = 1; ex_n++; ex_wait = pick_lat(); end
            if (e_wb) begin wb_busy = 1; wb_n++; wb_wait = pick_lat(); end
        end
        #1;
        drive();
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [SRC-1:0] mask);
        ins_t t;
        t.id   = id;
        t.mask = mask;
        src_q.push_back(t);
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int k;
        k = 0;
        while ((src_q.size() != 0 || n_ret != n_acc) && k < maxc) begin
            cycle();
            k++;
        end
        chk(tag, 32'(k < maxc), 32'd1);
    endtask

    // ---------------- scenario ----------------
    initial begin
        int b;
        int k;
        int wb0;
        rst_n = 1'b0;
        zero_inputs();
        lat_min = 0; lat_max = 0; valid_pct = 100; rr_pct = 100;
        hold_dones = 0; wb_obs = 0;
        model_reset();
        repeat (2) cycle();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_ready", 32'(ctrl_ready_o), 32'd1);
        chk("rst_cnt", 32'(inflight_cnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_resp_id", 32'(resp_stream_id_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);

        // Single instruction, minimum latency
        b = n_acc;
        push(8'h05, 3'b101);
        wait_drain("single_drain", 40);
        chk("lat_og", 32'(og_sc[b] - acc_c[b]), 32'd1);
        chk("lat_ex", 32'(ex_sc[b] - acc_c[b]), 32'd3);
        chk("lat_wb", 32'(wb_sc[b] - acc_c[b]), 32'd5);
        chk("lat_resp", 32'(rsp_c[b] - acc_c[b]), 32'd7);
        chk("single_rden", 32'(rd_obs[b]), 32'b101);
        chk("single_id", 32'(id_obs[b]), 32'h05);

        // Fill to depth with dones held, then release
        b = n_acc;
        hold_dones = 1;
        for (int i = 0; i < 5; i++) push(IDW'(8'h10 + i), SRC'($urandom_range(7, 0)));
        repeat (10) cycle();
        chk("full_cnt", 32'(inflight_cnt_o), 32'd4);
        chk("full_ready", 32'(ctrl_ready_o), 32'd0);
        chk("full_pending", 32'(src_q.size()), 32'd1);
        hold_dones = 0;
        og_wait = 0; ex_wait = 0; wb_wait = 0;
        wait_drain("full_drain", 100);
        chk("fifth_after_retire", 32'(acc_c[b + 4] - ret_c[b]), 32'd1);

        // Overlap and pointer wrap over 10 instructions
        b = n_acc;
        for (int i = 1; i <= 10; i++) push(IDW'(i), SRC'($urandom_range(7, 0)));
        wait_drain("overlap_drain", 200);
        chk("overlap_og2_in_ex1",
            32'((og_sc[b + 1] >= ex_sc[b]) && (og_sc[b + 1] <= ex_dc[b])), 32'd1);
        for (int i = 0; i < 10; i++) chk("overlap_order", 32'(id_obs[b + i]), 32'(i + 1));

        // Response backpressure
        b = n_acc;
        rr_pct = 0;
        push(8'h21, 3'b011);
        push(8'h22, 3'b110);
        k = 0;
        while (!(resp_full && ex_dn == b + 2) && k < 60) begin cycle(); k++; end
        chk("bp_reach", 32'(k < 60), 32'd1);
        wb0 = wb_obs;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("bp_id_stable", 32'(resp_stream_id_o), 32'h21);
            chk("bp_valid_held", 32'(resp_valid_o), 32'd1);
        end
        chk("bp_wb_withheld", 32'(wb_obs - wb0), 32'd0);
        rr_pct = 100;
        wait_drain("bp_drain", 60);
        chk("bp_first", 32'(id_obs[b]), 32'h21);
        chk("bp_second", 32'(id_obs[b + 1]), 32'h22);

        // Randomized traffic
        lat_min = 0; lat_max = 3; valid_pct = 60; rr_pct = 70;
        for (int i = 0; i < 150; i++) push(IDW'($urandom), SRC'($urandom_range(7, 0)));
        wait_drain("rand_drain", 4000);
        lat_max = 0; valid_pct = 100; rr_pct = 100;

        // Stray exec_done while EXEC idle
        exec_done_i = 1'b1;
        cycle();
        chk("stray_err", 32'(err_o), 32'd1);
        b = n_acc;
        for (int i = 0; i < 3; i++) push(IDW'(8'h40 + i), SRC'($urandom_range(7, 0)));
        wait_drain("err_drain", 60);
        chk("err_sticky", 32'(err_o), 32'd1);
        for (int i = 0; i < 3; i++) chk("err_order", 32'(id_obs[b + i]), 32'(8'h40 + i));

        // Reset mid-flight
        for (int i = 0; i < 3; i++) push(IDW'(8'h50 + i), SRC'($urandom_range(7, 0)));
        repeat (5) cycle();
        rst_n = 1'b0;
        zero_inputs();
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_cnt", 32'(inflight_cnt_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_id", 32'(resp_stream_id_o), 32'd0);
        chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(ctrl_ready_o), 32'd1);
        repeat (3) cycle();
        opget_done_i = 1'b1;
        cycle();
        chk("post_rst_done_err", 32'(err_o), 32'd1);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
